// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the five-stage pipeline: load-use stalls, jump flushes and EX forwarding.
// Optional saturating stall/flush statistics are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rsID,
    input  logic [4:0]       rtID,
    input  logic             useRtID,
    input  logic [4:0]       rstoEX,
    input  logic [4:0]       rttoEX,
    input  logic [4:0]       rwtoEX,
    input  logic             RegWrtoEX,
    input  logic             MentoRegtoEX,
    input  logic [4:0]       rwtoMe,
    input  logic             RegWrtoMe,
    input  logic             MentoRegtoMe,
    input  logic [4:0]       rwtoWr,
    input  logic             RegWrtoWr,
    input  logic             jumpReq,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             loadad,
    output logic             jumpSuccess,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, stateNext;
    logic [2:0] cnt, cntNext;
    logic       luHaz;

    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        if (RegWrtoMe && !MentoRegtoMe && rwtoMe != 5'd0 && rwtoMe == src)
            return 2'b01;
        else if (RegWrtoWr && rwtoWr != 5'd0 && rwtoWr == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        luHaz = MentoRegtoEX && RegWrtoEX && (rwtoEX != 5'd0) &&
                ((rwtoEX == rsID) || (useRtID && rwtoEX == rtID));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // cnt holds the number of stall/flush cycles still owed after the current one
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        pcWrite     = 1'b0;
        ifidWrite   = 1'b0;
        loadad      = 1'b0;
        jumpSuccess = 1'b0;
        if (!rst_n) begin
            jumpSuccess = 1'b1;
            stateNext   = RUN;
            cntNext     = 3'd0;
        end else if (jumpReq) begin
            jumpSuccess = 1'b1;
            pcWrite     = 1'b1;
            ifidWrite   = 1'b1;
            stateNext   = (FL_RELOAD == 3'd0) ? RUN : FLUSH;
            cntNext     = FL_RELOAD;
        end else begin
            case (state)
                RUN: begin
                    if (luHaz) begin
                        loadad    = 1'b1;
                        stateNext = (LS_RELOAD == 3'd0) ? RUN : LDSTALL;
                        cntNext   = LS_RELOAD;
                    end else begin
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                    end
                end
                LDSTALL: begin
                    loadad  = 1'b1;
                    cntNext = cnt - 3'd1;
                    if (cnt <= 3'd1) stateNext = RUN;
                end
                FLUSH: begin
                    jumpSuccess = 1'b1;
                    pcWrite     = 1'b1;
                    ifidWrite   = 1'b1;
                    cntNext     = cnt - 3'd1;
                    if (cnt <= 3'd1) stateNext = RUN;
                end
                default: begin
                    stateNext = RUN;
                    cntNext   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (rst_n) begin
            fwdA = fwdSel(rstoEX);
            fwdB = fwdSel(rttoEX);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallQ, flushQ;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallQ <= '0;
            flushQ <= '0;
        end else begin
            if (loadad)  stallQ <= satInc(stallQ);
            if (jumpReq) flushQ <= satInc(flushQ);
        end
    end

    assign stallCnt = stallQ;
    assign flushCnt = flushQ;
`else
    assign stallCnt = '0;
    assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (LOAD_STALL_CYCLES=2, FLUSH_CYCLES=2, CNT_W=4).
// Counter expectations collapse to zero when HAZARD_PERF_CNT_EN is not defined.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rsID, rtID, rstoEX, rttoEX, rwtoEX, rwtoMe, rwtoWr;
    logic useRtID, RegWrtoEX, MentoRegtoEX, RegWrtoMe, MentoRegtoMe, RegWrtoWr, jumpReq;
    logic pcWrite, ifidWrite, loadad, jumpSuccess;
    logic [1:0] fwdA, fwdB;
    logic [3:0] stallCnt, flushCnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rsID(rsID), .rtID(rtID), .useRtID(useRtID),
        .rstoEX(rstoEX), .rttoEX(rttoEX),
        .rwtoEX(rwtoEX), .RegWrtoEX(RegWrtoEX), .MentoRegtoEX(MentoRegtoEX),
        .rwtoMe(rwtoMe), .RegWrtoMe(RegWrtoMe), .MentoRegtoMe(MentoRegtoMe),
        .rwtoWr(rwtoWr), .RegWrtoWr(RegWrtoWr), .jumpReq(jumpReq),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .loadad(loadad), .jumpSuccess(jumpSuccess),
        .fwdA(fwdA), .fwdB(fwdB), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;  logic useRt;
        logic [4:0] rwEX;    logic wrEX, memEX;
        logic [4:0] rsEX, rtEX, rwMe; logic wrMe, memMe;
        logic [4:0] rwWr;    logic wrWr, jump;
        logic pc, ld, js;    logic [1:0] fA, fB;
        int sc, fc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic [4:0] rs, rt, input logic useRt,
        input logic [4:0] rwEX, input logic wrEX, memEX,
        input logic [4:0] rsEX, rtEX, rwMe, input logic wrMe, memMe,
        input logic [4:0] rwWr, input logic wrWr, jump,
        input logic pc, ld, js, input logic [1:0] fA, fB, input int sc, fc);
        vec_t v;
        v.rs = rs; v.rt = rt; v.useRt = useRt; v.rwEX = rwEX; v.wrEX = wrEX; v.memEX = memEX;
        v.rsEX = rsEX; v.rtEX = rtEX; v.rwMe = rwMe; v.wrMe = wrMe; v.memMe = memMe;
        v.rwWr = rwWr; v.wrWr = wrWr; v.jump = jump;
        v.pc = pc; v.ld = ld; v.js = js; v.fA = fA; v.fB = fB; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    function automatic int expCnt(input int c);
        return PERF ? c : 0;
    endfunction

    task automatic apply(input vec_t v);
        rsID = v.rs; rtID = v.rt; useRtID = v.useRt;
        rwtoEX = v.rwEX; RegWrtoEX = v.wrEX; MentoRegtoEX = v.memEX;
        rstoEX = v.rsEX; rttoEX = v.rtEX; rwtoMe = v.rwMe; RegWrtoMe = v.wrMe; MentoRegtoMe = v.memMe;
        rwtoWr = v.rwWr; RegWrtoWr = v.wrWr; jumpReq = v.jump;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chkOut(input string nm, input vec_t v);
        chk({nm, ".pcWrite"},     32'(pcWrite),     32'(v.pc));
        chk({nm, ".ifidWrite"},   32'(ifidWrite),   32'(v.pc));
        chk({nm, ".loadad"},      32'(loadad),      32'(v.ld));
        chk({nm, ".jumpSuccess"}, 32'(jumpSuccess), 32'(v.js));
        chk({nm, ".fwdA"},        32'(fwdA),        32'(v.fA));
        chk({nm, ".fwdB"},        32'(fwdB),        32'(v.fB));
        chk({nm, ".stallCnt"},    32'(stallCnt),    32'(expCnt(v.sc)));
        chk({nm, ".flushCnt"},    32'(flushCnt),    32'(expCnt(v.fc)));
    endtask

    initial begin
        vec_t idle, haz, v;
        idle = mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 0,0);
        haz  = mk(8,0,0, 8,1,1, 0,0,0,0,0, 0,0,0, 0,1,0, 0,0, 0,0);

        // Load-use: two stall cycles, then rt path, zero dest, non-load producer
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 0,0));
        vq.push_back(mk(8,0,0, 8,1,1, 0,0,0,0,0, 0,0,0, 0,1,0, 0,0, 0,0));
        vq.push_back(mk(8,0,0, 8,1,1, 0,0,0,0,0, 0,0,0, 0,1,0, 0,0, 1,0));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 2,0));
        vq.push_back(mk(0,0,0, 0,1,1, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 2,0));
        vq.push_back(mk(3,9,1, 9,1,1, 0,0,0,0,0, 0,0,0, 0,1,0, 0,0, 2,0));
        vq.push_back(mk(3,9,1, 9,1,1, 0,0,0,0,0, 0,0,0, 0,1,0, 0,0, 3,0));
        vq.push_back(mk(3,9,0, 9,1,1, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 4,0));
        vq.push_back(mk(8,0,0, 8,1,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 4,0));
        // Forwarding: MEM over WB, WB only, loads not forwarded from MEM, r0 never
        vq.push_back(mk(0,0,0, 0,0,0, 5,0,5,1,0, 5,1,0, 1,0,0, 1,0, 4,0));
        vq.push_back(mk(0,0,0, 0,0,0, 5,0,5,0,0, 5,1,0, 1,0,0, 2,0, 4,0));
        vq.push_back(mk(0,0,0, 0,0,0, 5,0,5,1,1, 5,1,0, 1,0,0, 2,0, 4,0));
        vq.push_back(mk(0,0,0, 0,0,0, 0,5,0,1,0, 5,1,0, 1,0,0, 0,2, 4,0));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,1,0, 0,1,0, 1,0,0, 0,0, 4,0));
        vq.push_back(mk(0,0,0, 0,0,0, 3,7,7,1,0, 3,1,0, 1,0,0, 2,1, 4,0));
        // Jump: two flush cycles, then a re-jump during FLUSH extends it
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,1, 1,0,1, 0,0, 4,0));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,1, 0,0, 4,1));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 4,1));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,1, 1,0,1, 0,0, 4,1));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,1, 1,0,1, 0,0, 4,2));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,1, 0,0, 4,3));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 4,3));
        // Jump with load-use in the same cycle, and jump aborting a stall
        vq.push_back(mk(8,0,0, 8,1,1, 0,0,0,0,0, 0,0,1, 1,0,1, 0,0, 4,3));
        vq.push_back(mk(8,0,0, 8,1,1, 0,0,0,0,0, 0,0,0, 1,0,1, 0,0, 4,4));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 4,4));
        vq.push_back(mk(8,0,0, 8,1,1, 0,0,0,0,0, 0,0,0, 0,1,0, 0,0, 4,4));
        vq.push_back(mk(8,0,0, 8,1,1, 0,0,0,0,0, 0,0,1, 1,0,1, 0,0, 5,4));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,1, 0,0, 5,5));
        vq.push_back(mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0,0, 5,5));

        // Reset: hazard and forward-worthy inputs must be masked
        rst_n = 1'b0;
        v = mk(8,0,0, 8,1,1, 5,5,5,1,0, 5,1,0, 0,0,1, 0,0, 0,0);
        apply(v);
        #12;
        chkOut("reset", v);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(idle);
        #3;
        chkOut("release", idle);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            apply(vq[i]);
            #3;
            chkOut($sformatf("v%0d", i), vq[i]);
        end

        // Back-to-back hazards keep loadad high; stallCnt saturates at 15
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            apply(haz);
            #3;
            chk($sformatf("sat%0d.loadad", i), 32'(loadad), 32'd1);
        end
        @(posedge clk); #1;
        apply(idle);
        #3;
        chk("sat.stallCnt", 32'(stallCnt), 32'(expCnt(15)));
        chk("sat.flushCnt", 32'(flushCnt), 32'(expCnt(5)));
        chk("sat.pcWrite",  32'(pcWrite),  32'd1);

        // Reset in the middle of a flush abandons it and clears counters
        @(posedge clk); #1;
        v = idle; v.jump = 1'b1;
        apply(v);
        #3;
        chk("rstmid.js0", 32'(jumpSuccess), 32'd1);
        @(posedge clk); #1;
        apply(idle);
        rst_n = 1'b0;
        #3;
        chk("rstmid.js",       32'(jumpSuccess), 32'd1);
        chk("rstmid.pcWrite",  32'(pcWrite),     32'd0);
        chk("rstmid.stallCnt", 32'(stallCnt),    32'd0);
        chk("rstmid.flushCnt", 32'(flushCnt),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #3;
        chk("rstmid.run.js", 32'(jumpSuccess), 32'd0);
        chk("rstmid.run.pc", 32'(pcWrite),     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
